register_file_responder: RTL
============================

Name: register_file_responder

Overview:
- Responder end of the processor's register-file interface.
- Provides two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- After reset, and on request, a hardware sweep clears every register to zero before the block accepts traffic.
- Sits beside the pipelined core: decode reads, writeback writes.

Parameters:
- NUM_REGS, 32, number of architectural registers. Must be ≤ 2**ADDR_W.
- ADDR_W, 6, width of every address port.
- DATA_W, 32, register width.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- register_file_read_address_1  in  ADDR_W  read port 1 address.
- register_file_read_address_2  in  ADDR_W  read port 2 address.
- register_file_read_value_1  out  DATA_W  read port 1 data, combinational.
- register_file_read_value_2  out  DATA_W  read port 2 data, combinational.
- register_file_write_address  in  ADDR_W  write address.
- register_file_write_value  in  DATA_W  write data.
- register_file_write_enable  in  1  write strobe, sampled on the rising clock edge.
- clear_request  in  1  one-cycle pulse that restarts the clear sweep.
- ready  out  1  high when the sweep is complete and the block is serving traffic.
- clear_index  out  ADDR_W  entry currently being cleared; debug/visibility only.

Behaviour:
- Storage
  - Array of NUM_REGS x DATA_W, with no reset on the array itself (RAM-inferable).
  - Only the FSM and the counter use the asynchronous reset.
- FSM states: CLEAR, READY.
  - While reset is low: state=CLEAR, clear_index=1, ready=0. Read values are 0 (forced by CLEAR).
  - CLEAR:
    - Each cycle, write 0 to entry clear_index, then increment clear_index.
    - When clear_index==NUM_REGS-1, write that entry and go to READY on the same edge.
    - The sweep therefore takes NUM_REGS-1 cycles after reset deasserts.
    - clear_index then holds at NUM_REGS-1 until the next sweep.
  - READY:
    - ready=1.
    - clear_request=1 → next state CLEAR, clear_index=1, ready=0 from the next cycle.
  - clear_request while already in CLEAR: ignored. The sweep does not restart.
- Reads
  - Zero-latency combinational reads.
  - The result is 0 if any of these hold: address==0; address≥NUM_REGS; state==CLEAR.
  - Otherwise the result is the stored entry.
  - Address bits above log2(NUM_REGS) are not truncated. Such addresses are out of range and read 0.
- Writes
  - A write takes effect on the rising edge when all of the following hold: write_enable=1; state==READY; address≠0; address<NUM_REGS.
  - Data is visible on the read ports the following cycle.
  - Writes to address 0, to out-of-range addresses, or during CLEAR are silently dropped. Nothing is queued.
  - A write in the same cycle as clear_request in READY is performed. The sweep then overwrites it with 0.
- Both read ports may address the same entry. Both must return identical data.
- Reset asserted mid-sweep: the sweep restarts from index 1 after deassertion.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When a qualifying write (per the write rules above) targets the same address as a read port in the same cycle, that read port returns register_file_write_value combinationally.
  - This gives same-cycle write-then-read forwarding.
  - Each read port is compared independently.
- Undefined: a read returns the pre-write contents until the next cycle. There is no extra logic.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum type (CLEAR, READY);
  - defaults for NUM_REGS, ADDR_W, DATA_W;
  - a localparam for the last sweep index.
- One sub-module: regfile_clear_sequencer. It owns the FSM and the clear_index counter and provides clear_we, clear_addr and ready.
- The top level holds the array, the read muxing and the bypass.

Test Plan:
- Reset low for 3 cycles, then release.
  - ready must stay 0 for exactly 31 cycles, then go to 1.
  - Reads of addresses 1..31 must then all return 0.
- In READY, write 0xDEADBEEF to address 5, then read address 5 on both ports next cycle → both return 0xDEADBEEF.
  - Same-cycle read → old value (0) without the macro, 0xDEADBEEF with it.
- Write 0x12345678 to address 0 and to address 40, then read both → 0x0.
  - No other entry changes (check addresses 8 and 31 are unchanged).
- Write to address 7 while in CLEAR → dropped. After ready, address 7 reads 0.
- Fill addresses 1..31 with their own index. Pulse clear_request with a same-cycle write of 0xAA to address 3.
  - ready must fall the next cycle and return after 31 cycles.
  - All entries must read 0.
- Assert reset at sweep index 10, then release → clear_index restarts at 1 and ready takes a full 31 cycles to rise.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared types and default sizes for the register-file responder
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_e;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT   = 6;
  localparam int DATA_W_DEFAULT   = 32;

  localparam int LAST_SWEEP_INDEX_DEFAULT = NUM_REGS_DEFAULT - 1;

  // Entry 0 is hardwired, so the sweep runs from 1 up to this index.
  function automatic int last_sweep_index(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_sequencer.sv
`default_nettype none
// ============================================================================
// regfile_clear_sequencer : CLEAR/READY FSM and sweep index for the register file
// Revision                : 1.0
// ============================================================================
module regfile_clear_sequencer
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_request,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] FIRST_INDEX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_INDEX  = ADDR_W'(last_sweep_index(NUM_REGS));

  regfile_state_e    state_q, state_d;
  logic [ADDR_W-1:0] clear_index_q, clear_index_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLEAR;
      clear_index_q <= FIRST_INDEX;
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clear_index_d = clear_index_q;
    clear_we      = 1'b0;
    ready         = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_we = 1'b1;
        // The last entry is written on the same edge that enters READY.
        if (clear_index_q >= LAST_INDEX) begin
          state_d = READY;
        end else begin
          clear_index_d = clear_index_q + FIRST_INDEX;
        end
      end
      READY: begin
        ready = 1'b1;
        if (clear_request) begin
          state_d       = CLEAR;
          clear_index_d = FIRST_INDEX;
        end
      end
      default: begin
        state_d       = CLEAR;
        clear_index_d = FIRST_INDEX;
      end
    endcase
  end

  assign clear_addr = clear_index_q;

endmodule
`default_nettype wire

// File: rtl/register_file_responder.sv
`default_nettype none
// ============================================================================
// register_file_responder : 2R/1W register file, entry 0 hardwired to zero,
//                           hardware clear sweep. Option: REGFILE_WRITE_BYPASS_EN
// Revision                : 1.0
// ============================================================================
module register_file_responder
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] register_file_read_address_1,
  input  logic [ADDR_W-1:0] register_file_read_address_2,
  output logic [DATA_W-1:0] register_file_read_value_1,
  output logic [DATA_W-1:0] register_file_read_value_2,
  input  logic [ADDR_W-1:0] register_file_write_address,
  input  logic [DATA_W-1:0] register_file_write_value,
  input  logic              register_file_write_enable,
  input  logic              clear_request,
  output logic              ready,
  output logic [ADDR_W-1:0] clear_index
);

  localparam int                IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              write_ok;
  logic              mem_we_d;
  logic [IDX_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0] mem_data_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  regfile_clear_sequencer #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_sequencer (
    .clk           (clock),
    .rst_n         (reset),
    .clear_request (clear_request),
    .clear_we      (clear_we),
    .clear_addr    (clear_addr),
    .ready         (ready)
  );

  assign clear_index = clear_addr;

  // Upper address bits are compared in full, never truncated.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < NUM_REGS_EXT;
  endfunction

  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return (addr != '0) && in_range(addr);
  endfunction

  always_comb begin
    write_ok = register_file_write_enable && ready && addr_valid(register_file_write_address);
  end

  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    if (clear_we && in_range(clear_addr)) begin
      mem_we_d   = 1'b1;
      mem_addr_d = clear_addr[IDX_W-1:0];
    end else if (write_ok) begin
      mem_we_d   = 1'b1;
      mem_addr_d = register_file_write_address[IDX_W-1:0];
      mem_data_d = register_file_write_value;
    end
  end

  // Storage carries no reset so it can map onto RAM; the sweep clears it.
  always_ff @(posedge clock) begin
    if (mem_we_d) begin
      mem_q[mem_addr_d] <= mem_data_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = '0;
    if (ready && addr_valid(addr)) begin
      value = mem_q[addr[IDX_W-1:0]];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (write_ok && (addr == register_file_write_address)) begin
      value = register_file_write_value;
    end
`endif
    return value;
  endfunction

  always_comb begin
    register_file_read_value_1 = read_port(register_file_read_address_1);
    register_file_read_value_2 = read_port(register_file_read_address_2);
  end

endmodule
`default_nettype wire
